pellet_map: RTL and testbench

//  Writable pellet-state RAM for the maze, one 2-bit sprite code per 8x8 tile
//  (0 empty, 1 pellet, 2 power pellet; code 3 never stored).

---
 rtl/pellet_map.sv | 202 ++++++++++++++++++++
 tb/tb_pellet_map.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pellet_map.sv
// Pellet-state RAM for the maze with fill sequencer, eat handshake and remaining-pellet count.
// Optional score accumulator is enabled by defining PELLET_MAP_SCORE_EN.
module pellet_map #(
    parameter int unsigned  COLS  = 32,
    parameter int unsigned  ROWS  = 30,
    localparam int unsigned COL_W = $clog2(COLS),
    localparam int unsigned ROW_W = $clog2(ROWS),
    localparam int unsigned CNT_W = $clog2(COLS * ROWS + 1)
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             fill_req_i,
    output logic             busy_o,
    input  logic             eat_valid_i,
    output logic             eat_ready_o,
    input  logic [COL_W-1:0] eat_col_i,
    input  logic [ROW_W-1:0] eat_row_i,
    output logic             eat_hit_o,
    output logic             eat_power_o,
    input  logic [COL_W-1:0] scan_col_i,
    input  logic [ROW_W-1:0] scan_row_i,
    output logic [1:0]       scan_sprite_o,
    output logic [CNT_W-1:0] remaining_o,
    output logic             level_clear_o
`ifdef PELLET_MAP_SCORE_EN
    ,
    output logic [15:0]      score_o
`endif
);

    localparam int unsigned Tiles = COLS * ROWS;
    localparam int unsigned AddrW = $clog2(Tiles);

    typedef enum logic [1:0] {StIdle, StFill, StEatRd, StEatWr} state_e;

    state_e             state_q;
    logic [ROW_W-1:0]   fill_row_q;
    logic [COL_W-1:0]   fill_col_q;
    logic [ROW_W-1:0]   eat_row_q;
    logic [COL_W-1:0]   eat_col_q;
    logic               busy_q;
    logic               eat_hit_q;
    logic               eat_power_q;
    logic               level_clear_q;
    logic [CNT_W-1:0]   remaining_q;
    logic [1:0]         scan_sprite_q;
`ifdef PELLET_MAP_SCORE_EN
    logic [15:0]        score_q;
    logic [16:0]        score_sum;
`endif

    logic [1:0]         mem [Tiles];

    function automatic logic [AddrW-1:0] tile_addr(input logic [ROW_W-1:0] r,
                                                   input logic [COL_W-1:0] c);
        return AddrW'(r) * AddrW'(COLS) + AddrW'(c);
    endfunction

    logic               eat_in_range;
    logic [1:0]         eat_code;
    logic               scan_in_range;
    logic               fill_border;
    logic               fill_power;
    logic [1:0]         fill_code;
    logic               fill_last;
    logic               mem_we;
    logic [AddrW-1:0]   mem_waddr;
    logic [1:0]         mem_wdata;

    always_comb begin
        eat_in_range  = (32'(eat_row_q) < ROWS) && (32'(eat_col_q) < COLS);
        eat_code      = eat_in_range ? mem[tile_addr(eat_row_q, eat_col_q)] : 2'd0;
        scan_in_range = (32'(scan_row_i) < ROWS) && (32'(scan_col_i) < COLS);

        fill_border = (32'(fill_row_q) == 0) || (32'(fill_row_q) == ROWS - 1) ||
                      (32'(fill_col_q) == 0) || (32'(fill_col_q) == COLS - 1);
        fill_power  = ((32'(fill_row_q) == 1) || (32'(fill_row_q) == ROWS - 2)) &&
                      ((32'(fill_col_q) == 1) || (32'(fill_col_q) == COLS - 2));
        fill_code   = fill_border ? 2'd0 : (fill_power ? 2'd2 : 2'd1);
        fill_last   = (32'(fill_row_q) == ROWS - 1) && (32'(fill_col_q) == COLS - 1);

        mem_we    = 1'b0;
        mem_waddr = '0;
        mem_wdata = 2'd0;
        if (state_q == StFill) begin
            mem_we    = 1'b1;
            mem_waddr = tile_addr(fill_row_q, fill_col_q);
            mem_wdata = fill_code;
        end else if (state_q == StEatWr) begin
            // eat_hit_q is only set for an in-range nonzero tile, so it doubles as write enable
            mem_we    = eat_hit_q;
            mem_waddr = tile_addr(eat_row_q, eat_col_q);
            mem_wdata = 2'd0;
        end
    end

`ifdef PELLET_MAP_SCORE_EN
    always_comb begin
        score_sum = {1'b0, score_q} + ((eat_code == 2'd2) ? 17'd50 : 17'd10);
    end
`endif

    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // Read-before-write: a same-cycle write is not visible to the scan port
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            scan_sprite_q <= 2'd0;
        end else if (scan_in_range) begin
            scan_sprite_q <= mem[tile_addr(scan_row_i, scan_col_i)];
        end else begin
            scan_sprite_q <= 2'd0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q       <= StIdle;
            fill_row_q    <= '0;
            fill_col_q    <= '0;
            eat_row_q     <= '0;
            eat_col_q     <= '0;
            busy_q        <= 1'b0;
            eat_hit_q     <= 1'b0;
            eat_power_q   <= 1'b0;
            level_clear_q <= 1'b0;
            remaining_q   <= '0;
`ifdef PELLET_MAP_SCORE_EN
            score_q       <= 16'd0;
`endif
        end else begin
            eat_hit_q     <= 1'b0;
            eat_power_q   <= 1'b0;
            level_clear_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (fill_req_i) begin
                        state_q     <= StFill;
                        busy_q      <= 1'b1;
                        remaining_q <= '0;
                        fill_row_q  <= '0;
                        fill_col_q  <= '0;
                    end else if (eat_valid_i) begin
                        state_q   <= StEatRd;
                        eat_row_q <= eat_row_i;
                        eat_col_q <= eat_col_i;
                    end
                end
                StFill: begin
                    if (fill_code != 2'd0) begin
                        remaining_q <= remaining_q + CNT_W'(1);
                    end
                    if (fill_last) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end else if (32'(fill_col_q) == COLS - 1) begin
                        fill_col_q <= '0;
                        fill_row_q <= fill_row_q + ROW_W'(1);
                    end else begin
                        fill_col_q <= fill_col_q + COL_W'(1);
                    end
                end
                StEatRd: begin
                    state_q <= StEatWr;
                    if ((eat_code == 2'd1) || (eat_code == 2'd2)) begin
                        eat_hit_q   <= 1'b1;
                        eat_power_q <= (eat_code == 2'd2);
                        if (remaining_q != '0) begin
                            remaining_q   <= remaining_q - CNT_W'(1);
                            level_clear_q <= (remaining_q == CNT_W'(1));
                        end
`ifdef PELLET_MAP_SCORE_EN
                        score_q <= score_sum[16] ? 16'hFFFF : score_sum[15:0];
`endif
                    end
                end
                StEatWr: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign busy_o        = busy_q;
    assign eat_ready_o   = (state_q == StIdle) && !fill_req_i;
    assign eat_hit_o     = eat_hit_q;
    assign eat_power_o   = eat_power_q;
    assign scan_sprite_o = scan_sprite_q;
    assign remaining_o   = remaining_q;
    assign level_clear_o = level_clear_q;
`ifdef PELLET_MAP_SCORE_EN
    assign score_o       = score_q;
`endif

endmodule

// File: tb/tb_pellet_map.sv
// Self-checking bench for pellet_map: array model of the maze, pellet count and score.
// Define PELLET_MAP_SCORE_EN here as for the RTL to exercise the score port.
module tb_pellet_map;

    localparam int COLS  = 32;
    localparam int ROWS  = 30;
    localparam int COL_W = 5;
    localparam int ROW_W = 5;
    localparam int CNT_W = 10;
    localparam int TILES = COLS * ROWS;

    logic             clk_i = 1'b0;
    logic             reset_i = 1'b1;
    logic             fill_req_i = 1'b0;
    logic             busy_o;
    logic             eat_valid_i = 1'b0;
    logic             eat_ready_o;
    logic [COL_W-1:0] eat_col_i = '0;
    logic [ROW_W-1:0] eat_row_i = '0;
    logic             eat_hit_o;
    logic             eat_power_o;
    logic [COL_W-1:0] scan_col_i = '0;
    logic [ROW_W-1:0] scan_row_i = '0;
    logic [1:0]       scan_sprite_o;
    logic [CNT_W-1:0] remaining_o;
    logic             level_clear_o;
`ifdef PELLET_MAP_SCORE_EN
    logic [15:0]      score_o;
`endif

    pellet_map #(.COLS(COLS), .ROWS(ROWS)) dut (
        .clk_i         (clk_i),
        .reset_i       (reset_i),
        .fill_req_i    (fill_req_i),
        .busy_o        (busy_o),
        .eat_valid_i   (eat_valid_i),
        .eat_ready_o   (eat_ready_o),
        .eat_col_i     (eat_col_i),
        .eat_row_i     (eat_row_i),
        .eat_hit_o     (eat_hit_o),
        .eat_power_o   (eat_power_o),
        .scan_col_i    (scan_col_i),
        .scan_row_i    (scan_row_i),
        .scan_sprite_o (scan_sprite_o),
        .remaining_o   (remaining_o),
        .level_clear_o (level_clear_o)
`ifdef PELLET_MAP_SCORE_EN
        ,
        .score_o       (score_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    int n_vec = 0;
    int n_err = 0;

    int model [ROWS][COLS];
    int model_rem   = 0;
    int model_score = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Maze layout from the rules: border empty, four power pellets inside the corners
    function automatic int layout(input int r, input int c);
        if (r == 0 || r == ROWS - 1 || c == 0 || c == COLS - 1) return 0;
        if ((r == 1 || r == ROWS - 2) && (c == 1 || c == COLS - 2)) return 2;
        return 1;
    endfunction

    task automatic model_fill();
        model_rem = 0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                model[r][c] = layout(r, c);
                if (model[r][c] != 0) model_rem++;
            end
        end
    endtask

    task automatic run_fill(input bit with_eat);
        int cyc = 0;
        int pulses = 0;
        fill_req_i  = 1'b1;
        eat_valid_i = with_eat;
        eat_row_i   = ROW_W'(2);
        eat_col_i   = COL_W'(2);
        #1;
        check("ready_low_on_fill_req", eat_ready_o, 0);
        @(posedge clk_i);
        #1;
        fill_req_i  = 1'b0;
        eat_valid_i = 1'b0;
        while (busy_o === 1'b1 && cyc < 2000) begin
            cyc++;
            if (eat_hit_o || level_clear_o) pulses++;
            fill_req_i = (cyc == 100);
            tick();
        end
        fill_req_i = 1'b0;
        check("fill_busy_cycles", cyc, TILES);
        check("fill_no_pulses", pulses, 0);
        model_fill();
        check("fill_remaining", remaining_o, model_rem);
        check("ready_after_fill", eat_ready_o, 1);
    endtask

    task automatic scan_at(input int r, input int c);
        int exp;
        scan_row_i = ROW_W'(r);
        scan_col_i = COL_W'(c);
        tick();
        exp = (r < ROWS && c < COLS) ? model[r][c] : 0;
        check($sformatf("scan(%0d,%0d)", r, c), scan_sprite_o, exp);
    endtask

    task automatic do_eat(input int r, input int c, output bit lc);
        int  code;
        int  w = 0;
        bit  exp_hit;
        bit  exp_lc;
        while (eat_ready_o !== 1'b1 && w < 20) begin
            tick();
            w++;
        end
        check("eat_ready_wait", eat_ready_o, 1);
        code    = (r < ROWS && c < COLS) ? model[r][c] : 0;
        exp_hit = (code != 0);
        exp_lc  = exp_hit && (model_rem == 1);
        eat_row_i   = ROW_W'(r);
        eat_col_i   = COL_W'(c);
        eat_valid_i = 1'b1;
        tick();
        eat_valid_i = 1'b0;
        check("eat_hit_early", eat_hit_o, 0);
        tick();
        if (exp_hit) begin
            model[r][c] = 0;
            if (model_rem > 0) model_rem--;
            model_score = model_score + ((code == 2) ? 50 : 10);
            if (model_score > 65535) model_score = 65535;
        end
        check($sformatf("eat_hit(%0d,%0d)", r, c), eat_hit_o, exp_hit);
        check("eat_power", eat_power_o, (code == 2));
        check("eat_remaining", remaining_o, model_rem);
        check("eat_level_clear", level_clear_o, exp_lc);
        check("eat_ready_busy", eat_ready_o, 0);
`ifdef PELLET_MAP_SCORE_EN
        check("eat_score", score_o, model_score);
`endif
        lc = level_clear_o;
        tick();
        check("eat_ready_back", eat_ready_o, 1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit lc;
        int lc_count;

        // Reset state
        reset_i = 1'b1;
        tick();
        tick();
        check("rst_busy", busy_o, 0);
        check("rst_remaining", remaining_o, 0);
        check("rst_eat_hit", eat_hit_o, 0);
        check("rst_eat_power", eat_power_o, 0);
        check("rst_level_clear", level_clear_o, 0);
        check("rst_scan", scan_sprite_o, 0);
`ifdef PELLET_MAP_SCORE_EN
        check("rst_score", score_o, 0);
`endif
        reset_i = 1'b0;
        tick();
        check("ready_after_reset", eat_ready_o, 1);

        // Fill and spot-check layout
        run_fill(1'b0);
        scan_at(1, 1);
        scan_at(0, 5);
        scan_at(2, 2);
        scan_at(ROWS - 2, COLS - 2);
        scan_at(31, 4);
        for (int i = 0; i < 30; i++) scan_at($urandom_range(0, 31), $urandom_range(0, 31));

        // Directed eats
        do_eat(5, 5, lc);
        scan_at(5, 5);
        do_eat(5, 5, lc);
        do_eat(31, 3, lc);
        do_eat(30, 8, lc);
        do_eat(1, COLS - 2, lc);

        // Random eats, including out-of-range rows
        for (int i = 0; i < 150; i++) begin
            do_eat($urandom_range(0, 31), $urandom_range(0, 31), lc);
        end
        for (int i = 0; i < 20; i++) scan_at($urandom_range(0, 31), $urandom_range(0, 31));

        // Clear the whole maze back-to-back
        lc_count = 0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                if (model[r][c] != 0) begin
                    do_eat(r, c, lc);
                    if (lc) lc_count++;
                end
            end
        end
        check("level_clear_once", lc_count, 1);
        check("cleared_remaining", remaining_o, 0);
        do_eat(3, 3, lc);

        // Reset in the middle of a fill
        fill_req_i = 1'b1;
        tick();
        fill_req_i = 1'b0;
        for (int i = 0; i < 299; i++) tick();
        check("midfill_busy", busy_o, 1);
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        check("midfill_rst_busy", busy_o, 0);
        check("midfill_rst_remaining", remaining_o, 0);
        model_score = 0;
`ifdef PELLET_MAP_SCORE_EN
        check("midfill_rst_score", score_o, 0);
`endif
        tick();

        // Simultaneous fill_req and eat_valid: fill wins
        run_fill(1'b1);
        scan_at(2, 2);
        scan_at(ROWS - 2, 1);
        do_eat(ROWS - 2, 1, lc);
        do_eat(7, 9, lc);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
